uart_reg_cmd: RTL

- Command decoder between the UART receiver/transmitter and reg_bank.
- Assembles byte frames from the UART into write transactions on reg_bank's write port.
- Serves read requests by loading reg_bank output A and returning the 64-bit value over the UART, most significant byte first.
- Lets the host script register-bank contents over RS232 at 115200 baud.

---
 rtl/uart_reg_pkg.sv | 23 ++
 rtl/uart_byte_shifter.sv | 63 ++++++
 rtl/uart_reg_cmd.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_pkg.sv
// uart_reg_pkg: shared definitions for the UART register command decoder.
//   - Header opcodes (bits [7:6] of the first byte of a frame).
//   - FSM state encoding used by uart_reg_cmd.
//   - Default register width and the byte count derived from it.
package uart_reg_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int NBYTES_DEF = DATA_W_DEF / 8;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_DATA,
    S_WRITE,
    S_RD_REQ,
    S_RD_CAP,
    S_TX_BYTE,
    S_TX_GAP
  } state_t;

endpackage

// File: rtl/uart_byte_shifter.sv
// uart_byte_shifter: NBYTES-deep byte shift register.
//   Byte 0 is the least significant byte. A shift moves every byte one
//   position towards the MSB and inserts byte_in at byte 0, so bytes arriving
//   MSB-first end up in natural order, and the MSB byte is always the next
//   one to leave when serialising.
// Ports:
//   clock, reset_n  clock (posedge) and asynchronous active-low reset
//   clear           zero the whole register (highest priority)
//   load            parallel load from load_data
//   shift           shift left by one byte, byte_in enters at the bottom
//   load_data       parallel load value
//   byte_in         byte inserted on shift
//   data            the most significant OUT_BYTES bytes of the register
module uart_byte_shifter
  import uart_reg_pkg::*;
#(
  parameter int NBYTES    = NBYTES_DEF,
  parameter int OUT_BYTES = NBYTES
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   shift,
  input  logic [8*NBYTES-1:0]    load_data,
  input  logic [7:0]             byte_in,
  output logic [8*OUT_BYTES-1:0] data
);

  logic [8*NBYTES-1:0] all_bytes;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      logic [7:0] byte_reg;
      logic [7:0] shift_src;

      if (gi == 0) begin : g_first
        assign shift_src = byte_in;
      end else begin : g_chain
        assign shift_src = all_bytes[8*(gi-1) +: 8];
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          byte_reg <= '0;
        end else if (clear) begin
          byte_reg <= '0;
        end else if (load) begin
          byte_reg <= load_data[8*gi +: 8];
        end else if (shift) begin
          byte_reg <= shift_src;
        end
      end

      assign all_bytes[8*gi +: 8] = byte_reg;
    end
  endgenerate

  // Only the top window is exposed; the TX side needs just the next byte out.
  assign data = all_bytes[8*NBYTES-1 -: 8*OUT_BYTES];

endmodule

// File: rtl/uart_reg_cmd.sv
// uart_reg_cmd: byte-frame command decoder between a UART and reg_bank.
//   Header byte: [7:6] op, [5:4] endreg, [3:0] register index.
//   op 00 = write (followed by DATA_W/8 data bytes, MSB first),
//   op 01 = read (reply is DATA_W/8 bytes of reg_bank outA, MSB first),
//   op 1x = invalid (frame_err pulse).
// Ports:
//   clock, reset_n     clock (posedge) and asynchronous active-low reset
//   rxready, dout      received-byte strobe and byte from the UART receiver
//   txready            UART transmitter can accept a byte
//   txen, din          load-and-send strobe and byte to the UART transmitter
//   regwen, inA,       reg_bank write port: enable pulse, data,
//   selwreg, endreg    register index and write mode
//   seloutA, enrregA   reg_bank port A read index and load strobe
//   cnstA              port A constant select, tied to 0
//   outA               reg_bank registered output A
//   busy               FSM is not idle
//   frame_err          one-cycle pulse on bad opcode or inter-byte timeout
module uart_reg_cmd
  import uart_reg_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rxready,
  input  logic [7:0]        dout,
  input  logic              txready,
  output logic              txen,
  output logic [7:0]        din,
  output logic              regwen,
  output logic [DATA_W-1:0] inA,
  output logic [3:0]        selwreg,
  output logic [1:0]        endreg,
  output logic [3:0]        seloutA,
  output logic              enrregA,
  output logic              cnstA,
  input  logic [DATA_W-1:0] outA,
  output logic              busy,
  output logic              frame_err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  state_t state_reg, state_next;

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [TO_W-1:0]   to_reg, to_next;
  logic [5:0]        hdr_reg;
  logic [DATA_W-1:0] inA_reg;
  logic [3:0]        selwreg_reg;
  logic [1:0]        endreg_reg;
  logic [3:0]        seloutA_reg;
  logic              frame_err_reg;

  logic              err_next;
  logic              hdr_load;
  logic              wr_load;
  logic              rd_load;
  logic              rx_clear;
  logic              rx_shift;
  logic              tx_load;
  logic              tx_shift;

  logic [DATA_W-1:0] rx_data;
  logic [7:0]        tx_top;

  uart_byte_shifter #(
    .NBYTES    (NBYTES),
    .OUT_BYTES (NBYTES)
  ) u_rx_shift (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (rx_clear),
    .load      (1'b0),
    .shift     (rx_shift),
    .load_data ('0),
    .byte_in   (dout),
    .data      (rx_data)
  );

  uart_byte_shifter #(
    .NBYTES    (NBYTES),
    .OUT_BYTES (1)
  ) u_tx_shift (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (1'b0),
    .load      (tx_load),
    .shift     (tx_shift),
    .load_data (outA),
    .byte_in   (8'h00),
    .data      (tx_top)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    to_next    = to_reg;
    err_next   = 1'b0;
    hdr_load   = 1'b0;
    wr_load    = 1'b0;
    rd_load    = 1'b0;
    rx_clear   = 1'b0;
    rx_shift   = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (rxready) begin
          case (dout[7:6])
            OP_WRITE: begin
              hdr_load   = 1'b1;
              rx_clear   = 1'b1;
              cnt_next   = '0;
              to_next    = '0;
              state_next = S_RX_DATA;
            end
            OP_READ: begin
              rd_load    = 1'b1;
              state_next = S_RD_REQ;
            end
            default: err_next = 1'b1;
          endcase
        end
      end

      S_RX_DATA: begin
        if (rxready) begin
          rx_shift = 1'b1;
          to_next  = '0;
          if (cnt_reg == CNT_LAST) begin
            // The last byte is merged straight into inA below so the write
            // fires the very next cycle.
            wr_load    = 1'b1;
            cnt_next   = '0;
            state_next = S_WRITE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else if (to_reg == TO_LAST) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          to_next = to_reg + TO_W'(1);
        end
      end

      S_WRITE: state_next = S_IDLE;

      S_RD_REQ: state_next = S_RD_CAP;

      S_RD_CAP: begin
        tx_load    = 1'b1;
        cnt_next   = '0;
        state_next = S_TX_BYTE;
      end

      S_TX_BYTE: begin
        if (txready) state_next = S_TX_GAP;
      end

      // txready is still high in this cycle (the UART lowers it one cycle
      // after txen), so it must not be used to launch the next byte.
      S_TX_GAP: begin
        tx_shift = 1'b1;
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next   = cnt_reg + CNT_W'(1);
          state_next = S_TX_BYTE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      to_reg        <= '0;
      hdr_reg       <= '0;
      inA_reg       <= '0;
      selwreg_reg   <= '0;
      endreg_reg    <= '0;
      seloutA_reg   <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      to_reg        <= to_next;
      frame_err_reg <= err_next;
      if (hdr_load) hdr_reg <= dout[5:0];
      // inA/selwreg/endreg only change when a complete frame has arrived,
      // so an aborted or timed-out frame never disturbs the write port.
      if (wr_load) begin
        inA_reg     <= (rx_data << 8) | DATA_W'(dout);
        selwreg_reg <= hdr_reg[3:0];
        endreg_reg  <= hdr_reg[5:4];
      end
      if (rd_load) seloutA_reg <= dout[3:0];
    end
  end

  assign txen      = (state_reg == S_TX_BYTE) && txready;
  assign din       = tx_top;
  assign regwen    = (state_reg == S_WRITE);
  assign inA       = inA_reg;
  assign selwreg   = selwreg_reg;
  assign endreg    = endreg_reg;
  assign seloutA   = seloutA_reg;
  assign enrregA   = (state_reg == S_RD_REQ);
  assign cnstA     = 1'b0;
  assign busy      = (state_reg != S_IDLE);
  assign frame_err = frame_err_reg;

endmodule
